// File: rtl/alu_seq.sv
// alu_seq: registered ALU with NZCV flag register, carry-in ops and an iterative shift-add multiplier.
// Single-cycle ops register their result on the accept edge; MUL runs WIDTH iterations in the MUL state.
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       uop,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_alu,
  output logic             result_we,
  output logic [3:0]       flags_out,
  output logic             illegal
);
  localparam int LW = $clog2(WIDTH);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, alu_q, alu_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d;
  logic valid_q, valid_d, we_q, we_d, ill_q, ill_d;
  logic [SHAMT_W-1:0] s;
  logic [WIDTH-1:0] b, res, ror_r, acc_nx;
  logic [WIDTH:0] sum, lsl_x, lsr_x, asr_x;
  logic [3:0] fl;
  logic sub, cin, vld, we, ill, zn, accept;
  assign in_ready  = state_q == IDLE;
  assign accept    = in_valid && in_ready;
  assign out_valid = valid_q;
  assign out_alu   = alu_q;
  assign result_we = we_q;
  assign flags_out = flags_q;
  assign illegal   = ill_q;
  assign s     = rhs[SHAMT_W-1:0];
  assign sub   = uop == 5'd2 || uop == 5'd5 || uop == 5'd11;
  assign b     = sub ? ~rhs : rhs;
  assign cin   = (uop == 5'd2 || uop == 5'd5) ? 1'b1 : (uop == 5'd10 || uop == 5'd11) ? flags_q[2] : 1'b0;
  assign sum   = {1'b0, lhs} + {1'b0, b} + (WIDTH+1)'(cin);
  // Extra guard bit on each shift captures the last bit shifted out as the carry.
  assign lsl_x = {1'b0, lhs} << s;
  assign lsr_x = {lhs, 1'b0} >> s;
  assign asr_x = $signed({lhs, 1'b0}) >>> s;
  assign ror_r = (lhs >> s[LW-1:0]) | (lhs << (WIDTH - int'(s[LW-1:0])));
  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
  always_comb begin
    res = alu_q;
    fl  = flags_q;
    vld = 1'b1;
    we  = 1'b1;
    ill = 1'b0;
    zn  = 1'b1;
    case (uop)
      5'd0, 5'd14: begin vld = 1'b0; we = 1'b0; zn = 1'b0; end
      5'd1, 5'd2, 5'd5, 5'd10, 5'd11: begin
        res   = sum[WIDTH-1:0];
        fl[2] = sum[WIDTH];
        fl[0] = (lhs[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != lhs[WIDTH-1]);
        we    = uop != 5'd5;
      end
      5'd3: res = lhs & rhs;
      5'd4: res = lhs ^ rhs;
      5'd9: res = lhs | rhs;
      5'd8: begin res = rhs; zn = 1'b0; end
      5'd6: begin res = lsl_x[WIDTH-1:0]; fl[2] = s == '0 ? fl[2] : lsl_x[WIDTH]; end
      5'd7: begin res = lsr_x[WIDTH:1]; fl[2] = s == '0 ? fl[2] : lsr_x[0]; end
      5'd12: begin res = asr_x[WIDTH:1]; fl[2] = s == '0 ? fl[2] : asr_x[0]; end
      5'd13: begin res = ror_r; fl[2] = s == '0 ? fl[2] : ror_r[WIDTH-1]; end
      default: begin we = 1'b0; ill = 1'b1; zn = 1'b0; end
    endcase
    fl[3] = zn ? res == '0 : fl[3];
    fl[1] = zn ? res[WIDTH-1] : fl[1];
  end
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    alu_d    = alu_q;
    flags_d  = flags_q;
    valid_d  = 1'b0;
    we_d     = 1'b0;
    ill_d    = 1'b0;
    if (state_q == MUL) begin
      acc_d    = acc_nx;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + LW'(1);
      if (cnt_q == LW'(WIDTH-1)) begin
        state_d    = IDLE;
        alu_d      = acc_nx;
        flags_d[3] = acc_nx == '0;
        flags_d[1] = acc_nx[WIDTH-1];
        valid_d    = 1'b1;
        we_d       = 1'b1;
      end
    end else if (accept && uop == 5'd14) begin
      state_d  = MUL;
      acc_d    = '0;
      mcand_d  = lhs;
      mplier_d = rhs;
      cnt_d    = '0;
    end else if (accept) begin
      alu_d   = res;
      flags_d = fl;
      valid_d = vld;
      we_d    = we;
      ill_d   = ill;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      alu_q    <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      alu_q    <= alu_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
      we_q     <= we_d;
      ill_q    <= ill_d;
    end
  end
endmodule
